// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the bus SRAM responder.
// Provides the word/bit types, the responder FSM state encoding, the
// upper bound on inserted wait states and a byte-lane merge helper.
package cpu_defs;

    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } BusSramState_t;

    localparam int BUS_SRAM_MAX_WAIT = 15;

    // Replace the byte lanes selected by mask in old_word with those of new_word.
    function automatic Word_t merge_bytes(input Word_t old_word, input Word_t new_word,
                                          input logic [3:0] mask);
        Word_t w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_sram_array.sv
// Word-addressed storage for the bus SRAM responder.
// 2**ADDR_WIDTH words of 32 bits, asynchronous read, synchronous byte-masked
// write. Contents are deliberately not reset.
// Ports:
//   clk    in   write clock
//   we     in   write enable for the current address
//   addr   in   word index (shared by read and write)
//   mask   in   byte enables, bit i -> wdata[8i+7:8i]
//   wdata  in   write data
//   rdata  out  current contents of the addressed word
module bus_sram_array
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            mask,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    Word_t mem [2**ADDR_WIDTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merge_bytes(mem[addr], wdata, mask);
    end

endmodule

// File: rtl/bus_sram_responder.sv
// Bus slave answering CPU read/write requests from an on-chip SRAM window,
// inserting WAIT_CYCLES stall cycles before each access completes.
// Optional feature macro: BUS_SRAM_TRACE_EN -- when defined, a registered
// trace of every committed in-window write appears on trace_*; otherwise the
// trace ports are tied to 0.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   bus_read     in   read request, held until bus_stall low
//   bus_write    in   write request, held until bus_stall low
//   bus_address  in   byte address, bits [1:0] ignored
//   bus_mask     in   write byte enables
//   bus_data_wr  in   write data
//   bus_data_rd  out  read data, valid on read completion, held otherwise
//   bus_stall    out  request not yet served
//   bus_err      out  completion of an access outside the window
//   trace_we     out  committed-write strobe (one cycle after the write)
//   trace_addr   out  word-aligned byte address of the committed write
//   trace_data   out  full post-merge word of the committed write
module bus_sram_responder
    import cpu_defs::*;
#(
    parameter int          ADDR_WIDTH  = 14,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [31:0] bus_address,
    input  logic [3:0]  bus_mask,
    input  logic [31:0] bus_data_wr,
    output logic [31:0] bus_data_rd,
    output logic        bus_stall,
    output logic        bus_err,
    output logic        trace_we,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data
);

    localparam int         WAIT_EFF     = (WAIT_CYCLES > BUS_SRAM_MAX_WAIT) ? BUS_SRAM_MAX_WAIT
                                                                            : WAIT_CYCLES;
    localparam logic [3:0] WAIT_N       = 4'(WAIT_EFF);
    localparam logic [32:0] WINDOW_BYTES = 33'd4 << ADDR_WIDTH;

    BusSramState_t         state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  latch;
    logic [29:0]           lat_word;
    Bit_t                  lat_read, lat_write;

    logic                  req, changed, complete, we;
    logic [31:0]           offset;
    logic                  in_window;
    logic [ADDR_WIDTH-1:0] word_idx;
    Word_t                 rd_word, rd_now, rd_hold;

    assign req       = bus_read | bus_write;
    assign offset    = bus_address - BASE_ADDR;
    assign in_window = {1'b0, offset} < WINDOW_BYTES;
    assign word_idx  = offset[ADDR_WIDTH+1:2];

    // A request that differs from the one being waited on restarts the count.
    assign changed = (bus_address[31:2] != lat_word) | (bus_read != lat_read)
                   | (bus_write != lat_write);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Snapshot of the request being waited on; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (latch) begin
            lat_word  <= bus_address[31:2];
            lat_read  <= bus_read;
            lat_write <= bus_write;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (req && WAIT_EFF != 0) begin
                    state_next = WAIT;
                    cnt_next   = 4'd1;
                    latch      = 1'b1;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (changed) begin
                    cnt_next = 4'd1;
                    latch    = 1'b1;
                end else if (cnt < WAIT_N) begin
                    cnt_next = cnt + 4'd1;
                end else begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output logic; gated by rst_n so stall drops the moment reset asserts.
    always_comb begin
        bus_stall = 1'b0;
        complete  = 1'b0;
        if (rst_n && req) begin
            case (state)
                IDLE: begin
                    if (WAIT_EFF == 0) complete  = 1'b1;
                    else               bus_stall = 1'b1;
                end
                WAIT: begin
                    if (!changed && cnt >= WAIT_N) complete  = 1'b1;
                    else                           bus_stall = 1'b1;
                end
                default: bus_stall = 1'b0;
            endcase
        end
    end

    // Mask 0000 is a no-op and is not reported as a committed write.
    assign we      = complete & bus_write & in_window & (|bus_mask);
    assign bus_err = complete & ~in_window;

    bus_sram_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (word_idx),
        .mask  (bus_mask),
        .wdata (bus_data_wr),
        .rdata (rd_word)
    );

    // Array read happens before the write edge, so a combined read/write
    // returns the pre-write contents.
    assign rd_now = in_window ? rd_word : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rd_hold <= 32'h0;
        else if (complete && bus_read) rd_hold <= rd_now;
    end

    assign bus_data_rd = (complete && bus_read) ? rd_now : rd_hold;

`ifdef BUS_SRAM_TRACE_EN
    logic  trace_we_r;
    Word_t trace_addr_r, trace_data_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_we_r   <= 1'b0;
            trace_addr_r <= 32'h0;
            trace_data_r <= 32'h0;
        end else begin
            trace_we_r <= we;
            if (we) begin
                trace_addr_r <= {bus_address[31:2], 2'b00};
                trace_data_r <= merge_bytes(rd_word, bus_data_wr, bus_mask);
            end
        end
    end

    assign trace_we   = trace_we_r;
    assign trace_addr = trace_addr_r;
    assign trace_data = trace_data_r;
`else
    assign trace_we   = 1'b0;
    assign trace_addr = 32'h0;
    assign trace_data = 32'h0;
`endif

endmodule

// File: tb/tb_bus_sram_responder.sv
// Scoreboard bench for bus_sram_responder: one instance with two wait states,
// one with zero wait states. Stimulus pushes expected completions into a
// queue; monitors pop and compare at every completion.
module tb_bus_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        rd, wr, stall, err, t_we;
    logic [31:0] addr, wdata, rdata, t_addr, t_data;
    logic [3:0]  mask;

    logic        rd0, wr0, stall0, err0, t_we0;
    logic [31:0] addr0, wdata0, rdata0, t_addr0, t_data0;
    logic [3:0]  mask0;

    bus_sram_responder #(.ADDR_WIDTH(14), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_read(rd), .bus_write(wr), .bus_address(addr),
        .bus_mask(mask), .bus_data_wr(wdata), .bus_data_rd(rdata), .bus_stall(stall),
        .bus_err(err), .trace_we(t_we), .trace_addr(t_addr), .trace_data(t_data)
    );

    bus_sram_responder #(.ADDR_WIDTH(14), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus_read(rd0), .bus_write(wr0), .bus_address(addr0),
        .bus_mask(mask0), .bus_data_wr(wdata0), .bus_data_rd(rdata0), .bus_stall(stall0),
        .bus_err(err0), .trace_we(t_we0), .trace_addr(t_addr0), .trace_data(t_data0)
    );

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   checks = 0;
    int   passes = 0;
    int   stall_run = 0;
    int   txn2 = 0;
    int   txn0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor for the two-wait-state instance
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_run = 0;
        end else if (!(rd | wr)) begin
            stall_run = 0;
        end else if (stall) begin
            stall_run++;
        end else begin
            txn2++;
            if (q2.size() == 0) begin
                checks++;
                $display("FAIL unexpected_completion w2 txn %0d: got completion, expected none", txn2);
            end else begin
                e = q2.pop_front();
                check($sformatf("w2_stalls_txn%0d", txn2), 32'(stall_run), 32'(e.stalls));
                check($sformatf("w2_err_txn%0d", txn2), {31'b0, err}, {31'b0, e.err});
                if (e.chk_data) check($sformatf("w2_rdata_txn%0d", txn2), rdata, e.data);
            end
            stall_run = 0;
        end
    end

    // Monitor for the zero-wait-state instance: every request completes at once
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (rd0 | wr0)) begin
            txn0++;
            check($sformatf("w0_stall_txn%0d", txn0), {31'b0, stall0}, 32'h0);
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL unexpected_completion w0 txn %0d: got completion, expected none", txn0);
            end else begin
                e = q0.pop_front();
                check($sformatf("w0_err_txn%0d", txn0), {31'b0, err0}, {31'b0, e.err});
                if (e.chk_data) check($sformatf("w0_rdata_txn%0d", txn0), rdata0, e.data);
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        rd = r; wr = w; addr = a; mask = m; wdata = d;
    endtask

    task automatic expect2(input logic c, input logic [31:0] d, input logic e, input int s);
        exp_t x;
        x.chk_data = c; x.data = d; x.err = e; x.stalls = s;
        q2.push_back(x);
    endtask

    task automatic finish_req();
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall) break;
        end
        if (n == 40) begin
            checks++;
            $display("FAIL completion_timeout: got stall for 40 cycles, expected completion");
        end
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input logic c, input logic [31:0] ed,
                       input logic ee, input int s);
        expect2(c, ed, ee, s);
        drive(r, w, a, m, d);
        finish_req();
    endtask

    // Zero-wait vectors: {read, write, address, data, mask, expected data, expected err}
    typedef struct {
        logic        r, w;
        logic [31:0] a, d;
        logic [3:0]  m;
        logic [31:0] ed;
        logic        ee;
    } vec0_t;

    vec0_t v0 [7] = '{
        '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0},
        '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 4'hF, 32'h0, 1'b0},
        '{1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 4'hF, 32'h0, 1'b0},
        '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1111_1111, 1'b0},
        '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h2222_2222, 1'b0},
        '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h3333_3333, 1'b0},
        '{1'b1, 1'b0, 32'h0001_0000, 32'h0,         4'h0, 32'h0,         1'b1}
    };

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; mask0 = 4'h0; wdata0 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_err", {31'b0, err}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_trace_we", {31'b0, t_we}, 32'h0);
        check("reset_rdata_w0", rdata0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full write, read back, masked byte merge
        acc(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2);
        acc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        acc(1'b0, 1'b1, 32'h10, 4'h2, 32'h0000_AB00, 1'b0, 32'h0, 1'b0, 2);
        acc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0,         1'b1, 32'hDEAD_ABEF, 1'b0, 2);
        @(posedge clk);
        #1;
        check("rdata_hold", rdata, 32'hDEAD_ABEF);

        // Mask 0000 is a no-op; read+write returns pre-write data
        acc(1'b0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 2);
        acc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0,         1'b1, 32'hDEAD_ABEF, 1'b0, 2);
        acc(1'b1, 1'b1, 32'h10, 4'hF, 32'h1122_3344, 1'b1, 32'hDEAD_ABEF, 1'b0, 2);
        acc(1'b1, 1'b0, 32'h10, 4'h0, 32'h0,         1'b1, 32'h1122_3344, 1'b0, 2);

        // Out of window: write dropped (no aliasing onto word 0), read returns 0
        acc(1'b0, 1'b1, 32'h0,       4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 2);
        acc(1'b0, 1'b1, 32'h1_0000,  4'hF, 32'h5555_5555, 1'b0, 32'h0, 1'b1, 2);
        acc(1'b1, 1'b0, 32'h1_0000,  4'h0, 32'h0,         1'b1, 32'h0, 1'b1, 2);
        acc(1'b1, 1'b0, 32'h0,       4'h0, 32'h0,         1'b1, 32'hCAFE_F00D, 1'b0, 2);

        // Request dropped mid-wait: no write
        acc(1'b0, 1'b1, 32'h50, 4'hF, 32'hAAAA_0000, 1'b0, 32'h0, 1'b0, 2);
        drive(1'b0, 1'b1, 32'h50, 4'hF, 32'hBBBB_BBBB);
        @(negedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        acc(1'b1, 1'b0, 32'h50, 4'h0, 32'h0, 1'b1, 32'hAAAA_0000, 1'b0, 2);

        // Address change mid-wait: count restarts, only the new address written
        acc(1'b0, 1'b1, 32'h40, 4'hF, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0, 2);
        expect2(1'b0, 32'h0, 1'b0, 3);
        drive(1'b0, 1'b1, 32'h40, 4'hF, 32'h0101_0101);
        @(negedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h44, 4'hF, 32'h0202_0202);
        finish_req();
        acc(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'h0F0F_0F0F, 1'b0, 2);
        acc(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b1, 32'h0202_0202, 1'b0, 2);

        // Reset mid-wait: stall falls at once, pending write discarded
        acc(1'b0, 1'b1, 32'h60, 4'hF, 32'h6060_6060, 1'b0, 32'h0, 1'b0, 2);
        drive(1'b0, 1'b1, 32'h60, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_stall", {31'b0, stall}, 32'h0);
        check("reset_mid_rdata", rdata, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        acc(1'b1, 1'b0, 32'h60, 4'h0, 32'h0, 1'b1, 32'h6060_6060, 1'b0, 2);

        // Write trace
        acc(1'b0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 2);
`ifdef BUS_SRAM_TRACE_EN
        check("trace_we", {31'b0, t_we}, 32'h1);
        check("trace_addr", t_addr, 32'h20);
        check("trace_data", t_data, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("trace_we_pulse", {31'b0, t_we}, 32'h0);
`else
        check("trace_we_tied", {31'b0, t_we}, 32'h0);
        check("trace_data_tied", t_data, 32'h0);
`endif

        // Zero wait states: one access per cycle, back-to-back
        foreach (v0[i]) begin
            exp_t x;
            x.chk_data = v0[i].r; x.data = v0[i].ed; x.err = v0[i].ee; x.stalls = 0;
            q0.push_back(x);
            rd0 = v0[i].r; wr0 = v0[i].w; addr0 = v0[i].a; mask0 = v0[i].m; wdata0 = v0[i].d;
            @(posedge clk);
            #1;
        end
        rd0 = 1'b0; wr0 = 1'b0;

        for (int i = 0; i < 20 && (q2.size() != 0 || q0.size() != 0); i++) @(posedge clk);
        check("w2_queue_drained", 32'(q2.size()), 32'h0);
        check("w0_queue_drained", 32'(q0.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
